// File: rtl/mips_pkg.sv
// mips_pkg: widths and constants shared by the instruction-fetch path.
package mips_pkg;

    localparam int unsigned INSTR_W       = 32;
    localparam int unsigned IMEM_AW       = 10;
    localparam int unsigned FETCH_ENTRY_W = 32 + INSTR_W;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch result: the address it came from and the word read.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Word index into instruction memory for a byte address.
    function automatic logic [IMEM_AW-1:0] word_addr(input logic [31:0] addr);
        return addr[IMEM_AW+1:2];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry FIFO of fetch results with push, pop and flush.
// Flush wins over push/pop; a push into a full FIFO is dropped unless a pop
// frees a slot in the same cycle.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = FETCH_ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    // Qualify requests against the current fill level.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
    end

    // Storage, pointers and fill count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect, one outstanding
// memory read and a two-entry result FIFO towards decode.
// Optional feature macro: FETCH_PERF_CNT_EN adds the perf_stall_cnt output,
// a saturating count of cycles where decode holds off a valid entry.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic               fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt
`endif
);

    logic [31:0]  pc;
    logic [31:0]  inflight_pc;
    logic         inflight;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [1:0]   occ;
    logic [1:0]   occ_after_pop;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    // Request/push/pop decisions. Occupancy is taken after this cycle's pop
    // so a draining FIFO keeps one request per cycle flowing; the entry in
    // flight always counts against the two slots.
    always_comb begin
        pop           = instr_valid && instr_ready && !redirect;
        push          = inflight && !redirect;
        occ           = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
        occ_after_pop = occ - {1'b0, pop};
        imem_req      = rst && !redirect &&
                        ((occ_after_pop + {1'b0, inflight}) < 2'd2);
        fetch_err     = rst && redirect && (redirect_pc[1:0] != 2'b00);
        push_entry    = '{pc: inflight_pc, instr: imem_rdata};
    end

    // Fetch address and the single outstanding-read tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            pc       <= align_word(redirect_pc);
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign imem_addr   = word_addr(pc);
    assign instr_valid = !fifo_empty;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;

`ifdef FETCH_PERF_CNT_EN
    // Saturating count of cycles where decode stalls a valid entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
        end else if (instr_valid && !instr_ready && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit. Each request the
// reference model expects is queued with its address; the FIFO head is
// compared against the queue front every cycle.
`timescale 1ns/1ps
module tb_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               redirect = 1'b0;
    logic [31:0]        redirect_pc = '0;
    logic               instr_valid;
    logic               instr_ready = 1'b0;
    logic [INSTR_W-1:0] instr;
    logic [31:0]        instr_pc;
    logic               fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_err      (fetch_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];        // requested pcs, oldest first; last may be in flight
    logic        model_infl = 1'b0;
    logic [31:0] model_pc   = TB_RESET_PC;
    logic [31:0] model_perf = '0;

    // Memory content is a function of the byte address so each word is unique.
    function automatic logic [31:0] tag(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        model_infl = 1'b0;
        model_pc   = TB_RESET_PC;
        model_perf = '0;
    endtask

    // One clock cycle: drive inputs, check outputs on the falling edge,
    // advance the model, then return the read data one cycle after a request.
    task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
        int unsigned occ;
        logic        ev, ep, er, ee, pend;
        logic [31:0] pend_data;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
        occ = sb_q.size() - (model_infl ? 1 : 0);
        ev  = rst && (occ > 0);
        ep  = ev && rdy && !rd;
        er  = rst && !rd && ((sb_q.size() - (ep ? 1 : 0)) < 2);
        ee  = rst && rd && (rpc[1:0] != 2'b00);
        check("instr_valid", 32'(instr_valid), 32'(ev));
        if (ev) begin
            check("instr_pc", instr_pc, sb_q[0]);
            check("instr", instr, tag(sb_q[0]));
        end
        check("imem_req", 32'(imem_req), 32'(er));
        if (er) check("imem_addr", 32'(imem_addr), 32'(model_pc[11:2]));
        check("fetch_err", 32'(fetch_err), 32'(ee));
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall_cnt", perf_stall_cnt, model_perf);
`endif
        if (ev && !rdy && (model_perf != 32'hFFFF_FFFF)) model_perf++;
        pend      = 1'b0;
        pend_data = 32'hBAD0_BAD0;
        if (rd) begin
            sb_q.delete();
            model_infl = 1'b0;
            model_pc   = {rpc[31:2], 2'b00};
        end else begin
            if (ep) void'(sb_q.pop_front());
            model_infl = 1'b0;
            if (er) begin
                sb_q.push_back(model_pc);
                model_infl = 1'b1;
                pend       = 1'b1;
                pend_data  = tag(model_pc);
                model_pc   = model_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        imem_rdata = pend ? pend_data : 32'hBAD0_BAD0;
    endtask

    initial begin
        // Reset state while rst is held low.
        #1;
        check("rst imem_req", 32'(imem_req), 32'd0);
        check("rst instr_valid", 32'(instr_valid), 32'd0);
        check("rst instr", instr, 32'd0);
        check("rst instr_pc", instr_pc, 32'd0);
        check("rst fetch_err", 32'(fetch_err), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Streaming with decode always ready: one entry per cycle from cycle 2.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // Back-pressure until both slots are full, then reset mid-stream.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst instr_valid", 32'(instr_valid), 32'd0);
        check("midrst imem_req", 32'(imem_req), 32'd0);
        check("midrst instr_pc", instr_pc, 32'd0);
        check("midrst instr", instr, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Decode stalled from reset release: FIFO fills and requests stop.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0);
        check("stall instr_pc", instr_pc, TB_RESET_PC);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

        // Redirect with a read outstanding: the stale word must never appear.
        step(1'b1, 1'b1, 32'h0000_0040);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);

        // Misaligned redirect: error pulse, fetch continues from the word base.
        step(1'b1, 1'b1, 32'h0000_0046);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);

        // Address wrap at the top of the 32-bit space.
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // Redirect while decode is stalled with a full FIFO.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0101);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

        // Mixed traffic: random ready and occasional redirects.
        for (int i = 0; i < 60; i++) begin
            logic        r_rdy, r_rd;
            logic [31:0] r_pc;
            r_rdy = 1'($urandom_range(0, 1));
            r_rd  = ($urandom_range(0, 9) == 0);
            r_pc  = $urandom & 32'h0000_0FFF;
            step(r_rdy, r_rd, r_pc);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read strobe.
REQ-005 SHALL have port imem_addr  output  10  word address, equal to pc[11:2].
REQ-006 SHALL have port imem_rdata  input  32  read data, valid one cycle after imem_req.
REQ-007 SHALL have port redirect  input  1  branch/jump taken; load redirect_pc.
REQ-008 SHALL have port redirect_pc  input  32  new fetch address.
REQ-009 SHALL have port instr_valid  output  1  instr and instr_pc hold a valid entry for decode.
REQ-010 SHALL have port instr_ready  input  1  decode accepts the entry.
REQ-011 SHALL have port instr  output  32  instruction word at the FIFO head.
REQ-012 SHALL have port instr_pc  output  32  address of instr.
REQ-013 SHALL have port fetch_err  output  1  one-cycle pulse on a misaligned redirect.
REQ-014 SHALL have port perf_stall_cnt  output  32  decode back-pressure count; present only under FETCH_PERF_CNT_EN.

Function
REQ-015 SHALL hold a 2-entry FIFO of {pc, instr} and at most 1 in-flight read.
REQ-016 SHALL assert imem_req in a cycle only when occupancy + inflight < 2 and redirect is low.
REQ-017 SHALL advance pc by 4 on each issued request, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 SHALL push {request pc, imem_rdata} into the FIFO in the cycle after the request, unless the request was cancelled.
REQ-019 SHALL pop the head when instr_valid && instr_ready; an empty FIFO SHALL drive instr_valid low.
REQ-020 SHALL allow push and pop in the same cycle, leaving occupancy unchanged.
REQ-021 Redirect SHALL:
- load pc with {redirect_pc[31:2], 2'b00};
- empty the FIFO;
- mark any in-flight response as discarded;
- suppress any pop in that cycle;
- take priority over all other events.
REQ-022 SHALL make the first post-redirect request in the cycle after redirect.
REQ-023 SHALL pulse fetch_err high for exactly one cycle when redirect is high and redirect_pc[1:0] != 0.
REQ-024 SHALL hold instr and instr_pc stable while instr_valid && !instr_ready.
REQ-025 SHALL impose a latency of 2 cycles from request to instr_valid when the FIFO is empty and decode is ready.

Reset
REQ-026 SHALL, while rst is low, immediately force the following to their reset values:
- pc = RESET_PC;
- FIFO empty, inflight = 0;
- imem_req, instr_valid, fetch_err = 0;
- instr, instr_pc = 0;
- perf_stall_cnt = 0.
REQ-027 SHALL discard any request in flight when reset is asserted; its data SHALL never be pushed.
REQ-028 SHALL issue the first request (address RESET_PC) in the first clock edge cycle after rst deasserts.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN, when defined, SHALL add perf_stall_cnt:
- increments each cycle with instr_valid && !instr_ready;
- saturates at 32'hFFFF_FFFF.
REQ-030 Without FETCH_PERF_CNT_EN, the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-031 SHALL take from shared package mips_pkg:
- the instruction width (32);
- the IMEM address width (10);
- the default RESET_PC constant.
REQ-032 SHALL implement the FIFO as sub-module fetch_fifo: 2 entries, 64-bit payload, push/pop/flush, full/empty flags.

Verification
REQ-033 Reset release, instr_ready=1, imem_rdata=addr-tagged -> instr_pc 0x0, 0x4, 0x8 on consecutive cycles from cycle 2.
REQ-034 instr_ready=0 for 5 cycles -> FIFO fills, imem_req stays low, instr_pc stays 0x0, perf_stall_cnt=5 (macro on).
REQ-035 redirect=1, redirect_pc=0x40 with request in flight -> stale word never presented, next instr_pc=0x40.
REQ-036 redirect_pc=0x46 -> fetch_err high 1 cycle, next instr_pc=0x44.
REQ-037 pc=0xFFFF_FFFC -> next request address 0x0, imem_addr=0x000.
REQ-038 rst low mid-stream with 2 entries buffered -> instr_valid=0 immediately, restart at RESET_PC.
